// File: rtl/mc_sequencer.sv
// Multicycle RV32I control sequencer. Memory accesses use a req/ready handshake
// guarded by a stall watchdog; the core halts with a cause code until reset.
module mc_sequencer #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WAIT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 branch_taken,
    output logic                 imem_req,
    input  logic                 imem_ready,
    output logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 dmem_wren,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           writeback_mux,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_EXEC2     = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t                state_q, state_d;
    logic [1:0]            cause_q, cause_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_WIDTH-1:0]  cyc_q, inst_q;
    logic                  timeout_hit;
    logic                  is_r, is_i, is_load, is_store, is_branch;
    logic                  is_jal, is_jalr, is_lui, is_auipc, is_system, is_legal;

    // funct3 only feeds external debug compares
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_system = (opcode == OP_SYSTEM);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal |
                       is_jalr | is_lui | is_auipc | is_system;

    // wait_inc is the stall count including the current unready cycle
    assign wait_inc    = wait_q + WAIT_WIDTH'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_inc == WAIT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        wait_d        = '0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        dmem_wren     = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        writeback_mux = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    state_d = S_HALT;
                    cause_d = 2'b01;
                end else if (is_system) begin
                    state_d = S_HALT;
                    cause_d = 2'b10;
                end else if (is_lui) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_r) begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b00;
                end else if (is_auipc || is_jal || is_branch) begin
                    alu_src_a = 2'b00;
                    alu_src_b = 2'b10;
                end else begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                if (is_branch)                state_d = S_EXEC2;
                else if (is_load || is_store) state_d = S_MEM;
                else                          state_d = S_WRITEBACK;
            end
            S_EXEC2: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                pc_write  = 1'b1;
                pc_src    = branch_taken;
                state_d   = S_FETCH;
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_wren = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = is_jal | is_jalr;
                if (is_lui)                writeback_mux = 2'b10;
                else if (is_load)          writeback_mux = 2'b01;
                else if (is_jal || is_jalr) writeback_mux = 2'b11;
                else                       writeback_mux = 2'b00;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cause_q <= 2'b00;
            wait_q  <= '0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            if (state_q != S_HALT) cyc_q <= cyc_q + CNT_WIDTH'(1);
            if (pc_write)          inst_q <= inst_q + CNT_WIDTH'(1);
        end
    end

    assign halted        = (state_q == S_HALT);
    assign halt_cause    = cause_q;
    assign state         = state_q;
    assign cycle_count   = cyc_q;
    assign instret_count = inst_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-class instruction table plus hand-written
// stall, halt, watchdog and mid-operation reset sequences.
module tb_mc_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken;
    logic        imem_req, imem_ready, dmem_req, dmem_ready;
    logic        pc_write, ir_write, reg_write, dmem_wren, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, writeback_mux;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [2:0]  state;
    logic [31:0] cycle_count, instret_count;

    int checks = 0;
    int fails  = 0;

    mc_sequencer #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(5), .WAIT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .reg_write(reg_write), .dmem_wren(dmem_wren),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .writeback_mux(writeback_mux), .halted(halted), .halt_cause(halt_cause),
        .state(state), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         lat;
        logic       rw;
        logic [1:0] wbm;
        logic       ps;
        logic       wr;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    // Runs one instruction from FETCH with zero-wait memories; stops after the retire edge.
    task automatic run_instr(input logic [6:0] op, input logic bt, output int lat,
                             output logic rw, output logic [1:0] wbm, output logic ps,
                             output logic wr, output logic [1:0] ea, output logic [1:0] eb);
        opcode = op; branch_taken = bt; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        lat = 0; rw = 1'b0; wbm = 2'b00; ps = 1'b0; wr = 1'b0; ea = 2'b11; eb = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            if (state == 3'd2) begin
                ea = alu_src_a;
                eb = alu_src_b;
            end
            if (pc_write) begin
                lat = c; rw = reg_write; wbm = writeback_mux; ps = pc_src; wr = dmem_wren;
                break;
            end
            cyc();
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat, nreq, c0, i0;
        logic rw, ps, wr, wren_seen;
        logic [1:0] wbm, ea, eb;

        vecs[0] = '{7'b0110011, 1'b0, 4, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00}; // ADD
        vecs[1] = '{7'b0010011, 1'b0, 4, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10}; // ADDI
        vecs[2] = '{7'b0010111, 1'b0, 4, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10}; // AUIPC
        vecs[3] = '{7'b1101111, 1'b0, 4, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 2'b10}; // JAL
        vecs[4] = '{7'b1100111, 1'b0, 4, 1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'b10}; // JALR
        vecs[5] = '{7'b0110111, 1'b0, 3, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11, 2'b11}; // LUI
        vecs[6] = '{7'b1100011, 1'b1, 4, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b10}; // BEQ taken
        vecs[7] = '{7'b1100011, 1'b0, 4, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10}; // BEQ not taken
        vecs[8] = '{7'b0100011, 1'b0, 4, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 2'b10}; // SW
        vecs[9] = '{7'b0000011, 1'b0, 5, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10}; // LW

        reset_n = 1'b0; opcode = 7'h33; funct3 = 3'd0; branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) cyc();
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_cause", {30'd0, halt_cause}, 32'd0);
        chk("reset_cycles", cycle_count, 32'd0);
        chk("reset_instret", instret_count, 32'd0);

        // ADD 0x002081B3 straight after reset
        reset_n = 1'b1; opcode = 7'h33; funct3 = 3'd0;
        #1;
        chk("add_c1_ir_write", {31'd0, ir_write}, 32'd1);
        cyc(); cyc(); cyc();
        chk("add_c4_strobes", {30'd0, reg_write, pc_write}, 32'd3);
        cyc();
        chk("add_instret", instret_count, 32'd1);
        chk("add_cycles", cycle_count, 32'd4);

        for (int v = 0; v < 10; v++) begin
            c0 = cycle_count; i0 = instret_count;
            run_instr(vecs[v].op, vecs[v].bt, lat, rw, wbm, ps, wr, ea, eb);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_reg_write", v), {31'd0, rw}, {31'd0, vecs[v].rw});
            chk($sformatf("v%0d_wb_mux", v), {30'd0, wbm}, {30'd0, vecs[v].wbm});
            chk($sformatf("v%0d_pc_src", v), {31'd0, ps}, {31'd0, vecs[v].ps});
            chk($sformatf("v%0d_dmem_wren", v), {31'd0, wr}, {31'd0, vecs[v].wr});
            chk($sformatf("v%0d_alu_sel", v), {28'd0, ea, eb}, {28'd0, vecs[v].ea, vecs[v].eb});
            chk($sformatf("v%0d_instret", v), instret_count, i0 + 1);
            chk($sformatf("v%0d_cycles", v), cycle_count, c0 + vecs[v].lat);
        end

        // LW with dmem_ready held off for 3 request cycles
        opcode = 7'b0000011; imem_ready = 1'b1; dmem_ready = 1'b0;
        #1;
        lat = 0; nreq = 0; wren_seen = 1'b0; wbm = 2'b00;
        for (int c = 1; c <= 20; c++) begin
            if (dmem_req) begin
                nreq++;
                if (nreq == 4) begin
                    dmem_ready = 1'b1;
                    #1;
                end
            end
            if (dmem_wren) wren_seen = 1'b1;
            if (pc_write) begin
                lat = c; wbm = writeback_mux;
                break;
            end
            cyc();
        end
        dmem_ready = 1'b1;
        chk("lw_stall_req_cycles", nreq, 32'd4);
        chk("lw_stall_wren", {31'd0, wren_seen}, 32'd0);
        chk("lw_stall_wb_mux", {30'd0, wbm}, 32'd1);
        chk("lw_stall_latency", lat, 32'd8);
        cyc();

        // Illegal opcode, then ECALL: halt and freeze
        for (int h = 0; h < 2; h++) begin
            do_reset();
            opcode = (h == 0) ? 7'h7F : 7'b1110011;
            imem_ready = 1'b1;
            #1;
            cyc(); cyc();
            chk($sformatf("halt%0d_halted", h), {31'd0, halted}, 32'd1);
            chk($sformatf("halt%0d_cause", h), {30'd0, halt_cause}, (h == 0) ? 32'd1 : 32'd2);
            chk($sformatf("halt%0d_cycles", h), cycle_count, 32'd2);
            wren_seen = 1'b0;
            repeat (10) begin
                cyc();
                if (imem_req | dmem_req | pc_write | ir_write | reg_write | dmem_wren)
                    wren_seen = 1'b1;
            end
            chk($sformatf("halt%0d_strobes", h), {31'd0, wren_seen}, 32'd0);
            chk($sformatf("halt%0d_frozen_cycles", h), cycle_count, 32'd2);
            chk($sformatf("halt%0d_frozen_instret", h), instret_count, 32'd0);
            chk($sformatf("halt%0d_still_halted", h), {31'd0, halted}, 32'd1);
        end

        // Watchdog: fetch never ready
        do_reset();
        opcode = 7'h33; imem_ready = 1'b0;
        #1;
        repeat (4) cyc();
        chk("wdog_c5_not_halted", {31'd0, halted}, 32'd0);
        cyc();
        chk("wdog_halted", {31'd0, halted}, 32'd1);
        chk("wdog_cause", {30'd0, halt_cause}, 32'd3);

        // Watchdog: ready in the 5th stall cycle wins
        do_reset();
        imem_ready = 1'b0;
        #1;
        repeat (4) cyc();
        imem_ready = 1'b1;
        #1;
        cyc();
        chk("wdog_ready_wins_state", {29'd0, state}, 32'd1);
        chk("wdog_ready_wins_halted", {31'd0, halted}, 32'd0);

        // Reset during MEM of SW
        do_reset();
        opcode = 7'b0100011; imem_ready = 1'b1; dmem_ready = 1'b0;
        #1;
        cyc(); cyc(); cyc();
        chk("sw_mem_strobes", {29'd0, state, dmem_req, dmem_wren} , {27'd0, 3'd4, 1'b1, 1'b1});
        reset_n = 1'b0;
        cyc();
        chk("midrst_dmem", {30'd0, dmem_req, dmem_wren}, 32'd0);
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_counters", cycle_count | instret_count, 32'd0);
        reset_n = 1'b1;
        dmem_ready = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Parametrised multicycle RV32I control sequencer, the successor to the fixed-timing control unit. It drives the same datapath strobes and mux selects. It adds a request/ready handshake to instruction and data memory, so variable-latency memory stalls the core, and a timeout watchdog. It also adds a halt state with a cause code, plus cycle and retired-instruction counters. It sits beside the datapath in top, fed by the decoder fields and the ALU compare result.

Parameters:
CNT_WIDTH, 32, width of cycle_count and instret_count; both wrap modulo 2^CNT_WIDTH.
TIMEOUT_CYCLES, 255, max stalled cycles per memory wait before halting; 0 disables the watchdog.
WAIT_WIDTH, 8, width of the internal wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
opcode  in  7  decoded ir[6:0]
funct3  in  3  decoded ir[14:12]; not used for sequencing, passed only for debug compares
branch_taken  in  1  combinational branch-compare result from ALU, valid in EXEC2
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
dmem_req  out  1  data access request
dmem_ready  in  1  data access complete this cycle
pc_write, ir_write, reg_write, dmem_wren  out  1 each  datapath strobes
pc_src  out  1  0 = PC+4, 1 = target
alu_src_a  out  2  00 = pc, 01 = reg_a
alu_src_b  out  2  00 = reg_b, 01 = 4, 10 = reg_imm
writeback_mux  out  2  00 = alu_out, 01 = mem_data, 10 = imm, 11 = PC+4
halted  out  1  core halted
halt_cause  out  2  00 = none, 01 = illegal opcode, 10 = ECALL/EBREAK (opcode 1110011), 11 = memory timeout
state  out  3  current state, for debug
cycle_count  out  CNT_WIDTH  cycles since reset, excluding halted cycles
instret_count  out  CNT_WIDTH  retired instructions

Behaviour:
- Reset: sampled low at a clk edge puts state in FETCH and clears both counters, halt_cause, halted and the wait counter. It applies mid-operation too: all strobes and reqs are 0 in the cycle after reset is sampled. Select outputs are 00/0 whenever not specified below.
- States: FETCH, DECODE, EXECUTE, EXEC2, MEM, WRITEBACK, HALT.
- FETCH:
  - imem_req=1 every cycle until imem_ready.
  - In the imem_ready cycle: ir_write=1, then go to DECODE.
- DECODE, no strobes:
  - Illegal opcode (not R/I/LOAD/STORE/BRANCH/JAL/JALR/LUI/AUIPC/SYSTEM): go to HALT, cause 01.
  - SYSTEM: go to HALT, cause 10.
  - LUI: go to WRITEBACK.
  - Otherwise: go to EXECUTE.
- EXECUTE selects by class:
  - R: a=01, b=00.
  - I/LOAD/STORE/JALR: a=01, b=10.
  - AUIPC/JAL/BRANCH: a=00, b=10.
  - Next state: BRANCH goes to EXEC2; LOAD/STORE go to MEM; the rest go to WRITEBACK.
- EXEC2 (branch):
  - a=01, b=00.
  - pc_write=1, pc_src=branch_taken; retire; go to FETCH.
- MEM:
  - dmem_req=1 until dmem_ready; dmem_wren=1 throughout for STORE.
  - On dmem_ready, STORE: pc_write=1, pc_src=0, retire, go to FETCH.
  - On dmem_ready, LOAD: go to WRITEBACK.
- WRITEBACK:
  - reg_write=1 and pc_write=1.
  - writeback_mux: LUI 10; LOAD 01; JAL/JALR 11; else 00.
  - pc_src=1 for JAL/JALR, else 0.
  - Retire; go to FETCH.
- Retire: instret_count increments in exactly the cycle pc_write=1.
- cycle_count increments every cycle not in HALT and not in reset.
- Watchdog:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle req=1 with ready=0.
  - When it equals TIMEOUT_CYCLES (≠0) with ready still 0: next state HALT, cause 11.
  - If ready arrives in the same cycle, ready wins.
- HALT: all strobes and reqs are 0, halted=1, and the counters freeze. Only reset exits.
- Zero-wait latencies in cycles:
  - R/I/AUIPC/JAL/JALR: 4.
  - LUI: 3.
  - BRANCH: 4.
  - STORE: 4.
  - LOAD: 5.
  - Each wait cycle adds 1.
- ready with req=0 is ignored.

Test Plan:
- Reset held 3 cycles, then ADD (0x002081B3) with imem_ready/dmem_ready tied 1 -> ir_write at cycle 1, reg_write+pc_write at cycle 4, instret_count=1, cycle_count=4.
- LW with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_wren=0, writeback_mux=01 in WRITEBACK, total 8 cycles.
- BEQ taken (branch_taken=1) then not taken -> EXEC2 pc_src=1 then 0, no reg_write, 4 cycles each.
- Opcode 0x7F; separately ECALL 0x00000073 -> halted=1 with halt_cause 01 and 10 respectively, counters frozen over 10 further cycles.
- TIMEOUT_CYCLES=5, imem_ready=0 forever -> HALT with cause 11 after 5 stalled cycles; ready in the 5th stall cycle instead -> no halt.
- reset_n low during MEM of SW -> next cycle dmem_wren=0, dmem_req=0, state=FETCH, counters=0.
